// File: rtl/audio_pkt_mc_if.sv
// UDP TX handshake bundle between the audio packetiser and the UDP TX core.
//   udp_tx_req      : UDP core requests one 32-bit word
//   udp_tx_done     : UDP core finished (or abandoned) the packet
//   udp_tx_start_en : one-cycle packet start pulse from the packetiser
//   udp_tx_data     : word returned one cycle after each request
//   udp_tx_byte_num : constant payload length in bytes
interface audio_pkt_mc_if;
  logic        udp_tx_req;
  logic        udp_tx_done;
  logic        udp_tx_start_en;
  logic [31:0] udp_tx_data;
  logic [15:0] udp_tx_byte_num;

  modport master (
    input  udp_tx_req,
    input  udp_tx_done,
    output udp_tx_start_en,
    output udp_tx_data,
    output udp_tx_byte_num
  );

  modport slave (
    output udp_tx_req,
    output udp_tx_done,
    input  udp_tx_start_en,
    input  udp_tx_data,
    input  udp_tx_byte_num
  );
endinterface

// File: rtl/audio_pkt_mc.sv
// Multi-channel audio UDP packetiser.
// Serialises CH_NUM-channel frames into MSB-aligned 16-bit slots, packs slot
// pairs into 32-bit FIFO words and streams fixed-size packets (optional
// sync/sequence header word followed by PKT_WORDS data words) to the UDP core.
// Ports:
//   eth_tx_clk    : sole clock
//   rst_n         : asynchronous active-low reset
//   transfer_flag : 1 = streaming, 0 = synchronous flush of all state
//   audio_en      : one-cycle frame strobe
//   audio_data    : CH_NUM*SAMPLE_W frame, ch0 in the LSBs
//   udp           : UDP TX handshake (master side)
//   fifo_ovf      : sticky overflow (dropped strobe or FIFO full)
//   pkt_seq       : sequence number of the next packet
module audio_pkt_mc #(
  parameter int CH_NUM     = 2,
  parameter int SAMPLE_W   = 16,
  parameter int PKT_WORDS  = 256,
  parameter int FIFO_DEPTH = 1024,
  parameter int HDR_EN     = 1
) (
  input  logic                       eth_tx_clk,
  input  logic                       rst_n,
  input  logic                       transfer_flag,
  input  logic                       audio_en,
  input  logic [CH_NUM*SAMPLE_W-1:0] audio_data,
  audio_pkt_mc_if.master             udp,
  output logic                       fifo_ovf,
  output logic [15:0]                pkt_seq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(PKT_WORDS + 1);
  localparam logic [AW:0]   PKT_CNT  = PKT_WORDS[AW:0];
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [PW-1:0] PAY_LAST = PW'(PKT_WORDS - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAY, WAIT_DONE} state_t;

  // ---------------- serialiser ----------------
  logic [CH_NUM*16-1:0] frame_slots;
  logic [CH_NUM*16-1:0] shift_q;
  logic [3:0]           slot_cnt_q;
  logic                 slot_vld;
  logic [15:0]          slot;
  logic                 ser_busy;
  logic                 ser_load;

  always_comb begin
    frame_slots = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      frame_slots[c*16 +: 16] = 16'(audio_data[c*SAMPLE_W +: SAMPLE_W]) << (16 - SAMPLE_W);
    end
  end

  assign slot_vld = (slot_cnt_q != 4'd0);
  assign slot     = shift_q[15:0];
  // The last slot of a frame leaves on the same edge a new frame loads, so a
  // strobe exactly CH_NUM cycles after the previous one is accepted.
  assign ser_busy = (slot_cnt_q > 4'd1);
  assign ser_load = audio_en && !ser_busy;

  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      slot_cnt_q <= '0;
    end else if (!transfer_flag) begin
      slot_cnt_q <= '0;
    end else if (ser_load) begin
      shift_q    <= frame_slots;
      slot_cnt_q <= 4'(CH_NUM);
    end else if (slot_vld) begin
      shift_q    <= shift_q >> 16;
      slot_cnt_q <= slot_cnt_q - 4'd1;
    end
  end

  // ---------------- packer ----------------
  logic [15:0] half_q;
  logic        half_vld_q;
  logic        wr_en;
  logic [31:0] wr_data;

  assign wr_en   = transfer_flag && slot_vld && half_vld_q;
  assign wr_data = {slot, half_q};

  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q     <= '0;
      half_vld_q <= 1'b0;
    end else if (!transfer_flag) begin
      half_vld_q <= 1'b0;
    end else if (slot_vld) begin
      if (!half_vld_q) begin
        half_q     <= slot;
        half_vld_q <= 1'b1;
      end else begin
        half_vld_q <= 1'b0;
      end
    end
  end

  // ---------------- FIFO ----------------
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full;
  logic          push;
  logic          pop;
  state_t        state_q;

  assign full = (count_q == FULL_CNT);
  assign push = wr_en && !full;
  assign pop  = transfer_flag && (state_q == PAY) && udp.udp_tx_req && !udp.udp_tx_done;

  always_ff @(posedge eth_tx_clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (!transfer_flag) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n)
      fifo_ovf <= 1'b0;
    else if (!transfer_flag)
      fifo_ovf <= 1'b0;
    else if ((audio_en && ser_busy) || (wr_en && full))
      fifo_ovf <= 1'b1;
  end

  // ---------------- packet FSM ----------------
  logic [PW-1:0] pay_cnt_q;
  logic [31:0]   resp;

  always_comb begin
    resp = '0;
    case (state_q)
      HDR:     resp = {16'hF55F, pkt_seq};
      PAY:     if (!udp.udp_tx_done) resp = mem[rd_ptr_q];
      default: resp = '0;
    endcase
  end

  assign udp.udp_tx_byte_num = 16'((PKT_WORDS + HDR_EN) * 4);

  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      pkt_seq             <= '0;
      pay_cnt_q           <= '0;
      udp.udp_tx_start_en <= 1'b0;
      udp.udp_tx_data     <= '0;
    end else if (!transfer_flag) begin
      state_q             <= IDLE;
      pkt_seq             <= '0;
      pay_cnt_q           <= '0;
      udp.udp_tx_start_en <= 1'b0;
      if (udp.udp_tx_req) udp.udp_tx_data <= '0;
    end else begin
      udp.udp_tx_start_en <= 1'b0;
      if (udp.udp_tx_req) udp.udp_tx_data <= resp;
      case (state_q)
        IDLE: begin
          if (count_q >= PKT_CNT) begin
            udp.udp_tx_start_en <= 1'b1;
            pay_cnt_q           <= '0;
            state_q             <= (HDR_EN != 0) ? HDR : PAY;
          end
        end
        HDR: begin
          if (udp.udp_tx_done) begin
            state_q <= IDLE;
            pkt_seq <= pkt_seq + 16'd1;
          end else if (udp.udp_tx_req) begin
            state_q <= PAY;
          end
        end
        PAY: begin
          // Abort leaves unread words in the FIFO for the next packet.
          if (udp.udp_tx_done) begin
            state_q <= IDLE;
            pkt_seq <= pkt_seq + 16'd1;
          end else if (udp.udp_tx_req) begin
            pay_cnt_q <= pay_cnt_q + 1'b1;
            if (pay_cnt_q == PAY_LAST) state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (udp.udp_tx_done) begin
            state_q <= IDLE;
            pkt_seq <= pkt_seq + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_pkt_mc.sv
module tb_audio_pkt_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  // DUT A: 2 ch x 16 bit, 4-word packets with header, 8-word FIFO
  logic        a_flag, a_en;
  logic [31:0] a_data;
  logic        a_ovf;
  logic [15:0] a_seq;
  audio_pkt_mc_if ifa ();

  audio_pkt_mc #(
    .CH_NUM(2), .SAMPLE_W(16), .PKT_WORDS(4), .FIFO_DEPTH(8), .HDR_EN(1)
  ) dut_a (
    .eth_tx_clk(clk), .rst_n(rst_n), .transfer_flag(a_flag), .audio_en(a_en),
    .audio_data(a_data), .udp(ifa), .fifo_ovf(a_ovf), .pkt_seq(a_seq)
  );

  // DUT B: 3 ch x 12 bit, 3-word packets without header
  logic        b_flag, b_en;
  logic [35:0] b_data;
  logic        b_ovf;
  logic [15:0] b_seq;
  audio_pkt_mc_if ifb ();

  audio_pkt_mc #(
    .CH_NUM(3), .SAMPLE_W(12), .PKT_WORDS(3), .FIFO_DEPTH(8), .HDR_EN(0)
  ) dut_b (
    .eth_tx_clk(clk), .rst_n(rst_n), .transfer_flag(b_flag), .audio_en(b_en),
    .audio_data(b_data), .udp(ifb), .fifo_ovf(b_ovf), .pkt_seq(b_seq)
  );

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic [31:0] d);
    a_data = d;
    a_en   = 1'b1;
    tick();
    a_en   = 1'b0;
    tick();
  endtask

  task automatic send_b(input logic [35:0] d);
    b_data = d;
    b_en   = 1'b1;
    tick();
    b_en   = 1'b0;
    tick(2);
  endtask

  task automatic read_w(input int sel, input string tag, input logic [31:0] exp);
    if (sel == 0) ifa.udp_tx_req = 1'b1; else ifb.udp_tx_req = 1'b1;
    tick();
    ifa.udp_tx_req = 1'b0;
    ifb.udp_tx_req = 1'b0;
    chk(tag, (sel == 0) ? ifa.udp_tx_data : ifb.udp_tx_data, exp);
  endtask

  task automatic done_w(input int sel);
    if (sel == 0) ifa.udp_tx_done = 1'b1; else ifb.udp_tx_done = 1'b1;
    tick();
    ifa.udp_tx_done = 1'b0;
    ifb.udp_tx_done = 1'b0;
  endtask

  // Counts cycles with start_en high in a bounded window.
  task automatic wait_start(input int sel, input string tag, input int exp_pulses);
    int n = 0;
    repeat (12) begin
      tick();
      if ((sel == 0) ? ifa.udp_tx_start_en : ifb.udp_tx_start_en) n++;
    end
    chk(tag, 32'(n), 32'(exp_pulses));
  endtask

  initial begin
    rst_n = 1'b0;
    a_flag = 1'b0; a_en = 1'b0; a_data = '0;
    b_flag = 1'b0; b_en = 1'b0; b_data = '0;
    ifa.udp_tx_req = 1'b0; ifa.udp_tx_done = 1'b0;
    ifb.udp_tx_req = 1'b0; ifb.udp_tx_done = 1'b0;
    tick(3);
    chk("rst_start", 32'(ifa.udp_tx_start_en), 32'h0);
    chk("rst_data", ifa.udp_tx_data, 32'h0);
    chk("rst_ovf", 32'(a_ovf), 32'h0);
    chk("rst_seq", 32'(a_seq), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("byte_num_a", 32'(ifa.udp_tx_byte_num), 32'd20);
    chk("byte_num_b", 32'(ifb.udp_tx_byte_num), 32'd12);

    // DUT B: odd channel count, pairing across frames, no header
    b_flag = 1'b1;
    tick();
    send_b({12'h333, 12'h222, 12'h111});
    send_b({12'h666, 12'h555, 12'h444});
    wait_start(1, "b_start", 1);
    read_w(1, "b_w0", 32'h22201110);
    read_w(1, "b_w1", 32'h44403330);
    read_w(1, "b_w2", 32'h66605550);
    read_w(1, "b_wait_zero", 32'h0);
    done_w(1);
    chk("b_seq", 32'(b_seq), 32'd1);
    chk("b_ovf", 32'(b_ovf), 32'h0);

    // DUT A: basic packet, strobes exactly CH_NUM cycles apart
    a_flag = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) send_a(32'hB000A000 + 32'(n) * 32'h00010001);
    wait_start(0, "a1_start", 1);
    read_w(0, "a1_hdr", 32'hF55F0000);
    read_w(0, "a1_w0", 32'hB000A000);
    read_w(0, "a1_w1", 32'hB001A001);
    read_w(0, "a1_w2", 32'hB002A002);
    read_w(0, "a1_w3", 32'hB003A003);
    tick();
    chk("a1_hold", ifa.udp_tx_data, 32'hB003A003);
    read_w(0, "a1_wait_zero", 32'h0);
    done_w(0);
    chk("a1_seq", 32'(a_seq), 32'd1);
    chk("a1_ovf", 32'(a_ovf), 32'h0);

    // Strobe one cycle after the previous one is dropped
    a_data = 32'h22221111; a_en = 1'b1;
    tick();
    a_data = 32'h44443333;
    tick();
    a_en = 1'b0;
    tick(2);
    chk("sp_ovf_set", 32'(a_ovf), 32'h1);
    send_a(32'h66665555);
    send_a(32'h88887777);
    send_a(32'hAAAA9999);
    wait_start(0, "sp_start", 1);
    read_w(0, "sp_hdr", 32'hF55F0001);
    read_w(0, "sp_w0", 32'h22221111);
    read_w(0, "sp_w1", 32'h66665555);
    read_w(0, "sp_w2", 32'h88887777);
    read_w(0, "sp_w3", 32'hAAAA9999);
    chk("sp_ovf_sticky", 32'(a_ovf), 32'h1);
    done_w(0);
    chk("sp_seq", 32'(a_seq), 32'd2);
    a_flag = 1'b0;
    tick();
    chk("sp_ovf_clear", 32'(a_ovf), 32'h0);
    chk("sp_seq_clear", 32'(a_seq), 32'h0);
    a_flag = 1'b1;
    tick();

    // FIFO full: 10 words into an 8-word FIFO with no reads
    for (int n = 0; n < 8; n++) send_a(32'hD000C000 + 32'(n) * 32'h00010001);
    tick(2);
    chk("full_ovf_at8", 32'(a_ovf), 32'h0);
    send_a(32'hD008C008);
    send_a(32'hD009C009);
    tick(2);
    chk("full_ovf_set", 32'(a_ovf), 32'h1);
    read_w(0, "full_hdr0", 32'hF55F0000);
    for (int n = 0; n < 4; n++) read_w(0, "full_p0", 32'hD000C000 + 32'(n) * 32'h00010001);
    done_w(0);
    wait_start(0, "full_start1", 1);
    read_w(0, "full_hdr1", 32'hF55F0001);
    for (int n = 4; n < 8; n++) read_w(0, "full_p1", 32'hD000C000 + 32'(n) * 32'h00010001);
    done_w(0);
    wait_start(0, "full_drained", 0);

    // Flush mid-packet
    for (int n = 0; n < 4; n++) send_a(32'h5A000000 + 32'(n));
    wait_start(0, "fl_start", 1);
    read_w(0, "fl_hdr", 32'hF55F0002);
    read_w(0, "fl_w0", 32'h5A000000);
    read_w(0, "fl_w1", 32'h5A000001);
    a_flag = 1'b0;
    tick();
    read_w(0, "fl_req_zero", 32'h0);
    chk("fl_seq", 32'(a_seq), 32'h0);
    a_flag = 1'b1;
    tick();
    wait_start(0, "fl_fifo_empty", 0);
    for (int n = 0; n < 4; n++) send_a(32'h3C000000 + 32'(n));
    wait_start(0, "fl_restart", 1);
    read_w(0, "fl_rhdr", 32'hF55F0000);
    for (int n = 0; n < 4; n++) read_w(0, "fl_rw", 32'h3C000000 + 32'(n));
    done_w(0);
    chk("fl_rseq", 32'(a_seq), 32'd1);

    // Sequence wrap
    force dut_a.pkt_seq = 16'hFFFF;
    tick();
    release dut_a.pkt_seq;
    tick();
    chk("wr_preload", 32'(a_seq), 32'h0000FFFF);
    for (int n = 0; n < 4; n++) send_a(32'h77000000 + 32'(n));
    wait_start(0, "wr_start", 1);
    read_w(0, "wr_hdr", 32'hF55FFFFF);
    for (int n = 0; n < 4; n++) read_w(0, "wr_w", 32'h77000000 + 32'(n));
    done_w(0);
    chk("wr_seq", 32'(a_seq), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
